// File: rtl/l1i_miss_handler.sv
// L1 instruction cache miss handler: captures one miss, requests the aligned
// line from memory, assembles the returned beats and writes the line back.
module l1i_miss_handler #(
   parameter int unsigned addressWidth            = 64,
   parameter int unsigned cacheLineWidth          = 512,
   parameter int unsigned beatWidth               = 128,
   parameter int unsigned offsetWidth             = 6,
   parameter int unsigned PidSize                 = 20,
   parameter int unsigned TidSize                 = 16,
   parameter int unsigned instructionCounterWidth = 64
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               cacheMiss_i,
   input  logic [addressWidth-1:0]            missedAddress_i,
   input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
   input  logic [PidSize-1:0]                 missedPid_i,
   input  logic [TidSize-1:0]                 missedTid_i,
   input  logic                               flush_i,
   output logic                               memReq_o,
   output logic [addressWidth-1:0]            memReqAddress_o,
   input  logic                               memReqReady_i,
   input  logic                               memDataValid_i,
   input  logic [beatWidth-1:0]               memData_i,
   output logic                               busy_o,
   output logic                               cacheUpdate_o,
   output logic [addressWidth-1:0]            cacheUpdateAddress_o,
   output logic [PidSize-1:0]                 cacheUpdatePid_o,
   output logic [TidSize-1:0]                 cacheUpdateTid_o,
   output logic [instructionCounterWidth-1:0] missedInstMajorId_o,
   output logic [cacheLineWidth-1:0]          cacheUpdateLine_o
);

   localparam int unsigned BeatsPerLine = cacheLineWidth / beatWidth;
   localparam int unsigned CntW         = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_FILL  = 3'd2,
      S_DRAIN = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t                  state, state_n;
   logic [CntW-1:0]         cnt, cnt_n;
   logic                    capture_c;
   logic                    store_c;
   logic                    last_beat_c;
   logic [addressWidth-1:0] aligned_addr_c;

   // Line-aligned version of the incoming miss address
   always_comb begin
      aligned_addr_c                   = missedAddress_i;
      aligned_addr_c[offsetWidth-1:0]  = '0;
   end

   assign last_beat_c = (cnt == CntW'(BeatsPerLine - 1));

   // State register and beat counter
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic; a flushed fill keeps counting beats but stops storing them
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      capture_c = 1'b0;
      store_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cacheMiss_i) begin
               capture_c = 1'b1;
               state_n   = S_REQ;
            end
         end
         S_REQ: begin
            if (memReqReady_i) begin
               cnt_n   = '0;
               state_n = flush_i ? S_DRAIN : S_FILL;
            end else if (flush_i) begin
               state_n = S_IDLE;
            end
         end
         S_FILL: begin
            if (memDataValid_i) begin
               store_c = !flush_i;
               cnt_n   = cnt + CntW'(1);
               if (last_beat_c) begin
                  state_n = flush_i ? S_IDLE : S_WRITE;
               end else if (flush_i) begin
                  state_n = S_DRAIN;
               end
            end else if (flush_i) begin
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (memDataValid_i) begin
               cnt_n = cnt + CntW'(1);
               if (last_beat_c) begin
                  state_n = S_IDLE;
               end
            end
         end
         S_WRITE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Registered control outputs track the state being entered
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         memReq_o      <= 1'b0;
         busy_o        <= 1'b0;
         cacheUpdate_o <= 1'b0;
      end else begin
         memReq_o      <= (state_n == S_REQ);
         busy_o        <= (state_n != S_IDLE);
         cacheUpdate_o <= (state_n == S_WRITE);
      end
   end

   // Miss payload capture and line assembly; beat 0 lands in the top slice
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         memReqAddress_o      <= '0;
         cacheUpdateAddress_o <= '0;
         cacheUpdatePid_o     <= '0;
         cacheUpdateTid_o     <= '0;
         missedInstMajorId_o  <= '0;
         cacheUpdateLine_o    <= '0;
      end else begin
         if (capture_c) begin
            memReqAddress_o      <= aligned_addr_c;
            cacheUpdateAddress_o <= aligned_addr_c;
            cacheUpdatePid_o     <= missedPid_i;
            cacheUpdateTid_o     <= missedTid_i;
            missedInstMajorId_o  <= missedInstMajorId_i;
         end
         for (int unsigned b = 0; b < BeatsPerLine; b++) begin
            if (store_c && (cnt == CntW'(b))) begin
               cacheUpdateLine_o[cacheLineWidth-1-b*beatWidth -: beatWidth] <= memData_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_l1i_miss_handler.sv
// Directed bench for l1i_miss_handler with a transaction-level reference model.
module tb_l1i_miss_handler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cache_miss;
   logic [63:0]  missed_address;
   logic [63:0]  missed_major;
   logic [19:0]  missed_pid;
   logic [15:0]  missed_tid;
   logic         flush;
   logic         mem_req;
   logic [63:0]  mem_req_address;
   logic         mem_ready;
   logic         mem_valid;
   logic [127:0] mem_data;
   logic         busy;
   logic         cache_update;
   logic [63:0]  upd_address;
   logic [19:0]  upd_pid;
   logic [15:0]  upd_tid;
   logic [63:0]  upd_major;
   logic [511:0] upd_line;

   int checks = 0;
   int errors = 0;
   int strobes = 0;

   always #5 clk = ~clk;

   l1i_miss_handler dut (
      .clock_i              (clk),
      .reset_i              (rst_n),
      .cacheMiss_i          (cache_miss),
      .missedAddress_i      (missed_address),
      .missedInstMajorId_i  (missed_major),
      .missedPid_i          (missed_pid),
      .missedTid_i          (missed_tid),
      .flush_i              (flush),
      .memReq_o             (mem_req),
      .memReqAddress_o      (mem_req_address),
      .memReqReady_i        (mem_ready),
      .memDataValid_i       (mem_valid),
      .memData_i            (mem_data),
      .busy_o               (busy),
      .cacheUpdate_o        (cache_update),
      .cacheUpdateAddress_o (upd_address),
      .cacheUpdatePid_o     (upd_pid),
      .cacheUpdateTid_o     (upd_tid),
      .missedInstMajorId_o  (upd_major),
      .cacheUpdateLine_o    (upd_line)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding miss, request phase, beats collected in order
   logic         m_active, m_reqd, m_discard, m_strobe;
   int           m_beats;
   logic [127:0] m_buf [4];
   logic [63:0]  m_addr, m_major;
   logic [19:0]  m_pid;
   logic [15:0]  m_tid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active  <= 1'b0;
         m_reqd    <= 1'b0;
         m_discard <= 1'b0;
         m_strobe  <= 1'b0;
         m_beats   <= 0;
         m_addr    <= '0;
         m_major   <= '0;
         m_pid     <= '0;
         m_tid     <= '0;
      end else if (m_strobe) begin
         m_strobe <= 1'b0;
      end else if (!m_active) begin
         if (cache_miss) begin
            m_active <= 1'b1;
            m_reqd   <= 1'b0;
            m_addr   <= (missed_address / 64) * 64;
            m_major  <= missed_major;
            m_pid    <= missed_pid;
            m_tid    <= missed_tid;
         end
      end else if (!m_reqd) begin
         if (mem_ready) begin
            m_reqd    <= 1'b1;
            m_beats   <= 0;
            m_discard <= flush;
         end else if (flush) begin
            m_active <= 1'b0;
         end
      end else begin
         if (mem_valid) begin
            if (!(m_discard || flush)) m_buf[m_beats] <= mem_data;
            m_beats <= m_beats + 1;
            if (m_beats == 3) begin
               m_active <= 1'b0;
               m_strobe <= !(m_discard || flush);
            end
         end
         if (flush) m_discard <= 1'b1;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 512'(busy), 512'(m_active || m_strobe));
         chk("mem_req", 512'(mem_req), 512'(m_active && !m_reqd));
         chk("cache_update", 512'(cache_update), 512'(m_strobe));
         if (m_active && !m_reqd) chk("req_address", 512'(mem_req_address), 512'(m_addr));
         if (m_strobe) begin
            chk("upd_address", 512'(upd_address), 512'(m_addr));
            chk("upd_pid", 512'(upd_pid), 512'(m_pid));
            chk("upd_tid", 512'(upd_tid), 512'(m_tid));
            chk("upd_major", 512'(upd_major), 512'(m_major));
            chk("upd_line", upd_line, {m_buf[0], m_buf[1], m_buf[2], m_buf[3]});
         end
         if (cache_update) strobes++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [63:0] a, input logic [63:0] id, input logic [19:0] p, input logic [15:0] t);
      cache_miss = 1'b1; missed_address = a; missed_major = id; missed_pid = p; missed_tid = t;
      tick();
      cache_miss = 1'b0;
   endtask

   task automatic do_beat(input logic [127:0] d);
      mem_valid = 1'b1; mem_data = d;
      tick();
      mem_valid = 1'b0; mem_data = '0;
   endtask

   task automatic do_ready();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   logic [127:0] ba, bb, bc, bd, be, bf, bg, bh;
   int gaps [3] = '{1, 3, 2};
   int s0;

   initial begin
      ba = {4{32'hA0A1A2A3}}; bb = {4{32'hB0B1B2B3}};
      bc = {4{32'hC0C1C2C3}}; bd = {4{32'hD0D1D2D3}};
      be = {4{32'hE0E1E2E3}}; bf = {4{32'hF0F1F2F3}};
      bg = {4{32'h01234567}}; bh = {4{32'h89ABCDEF}};
      rst_n = 1'b0; cache_miss = 1'b0; missed_address = '0; missed_major = '0;
      missed_pid = '0; missed_tid = '0; flush = 1'b0; mem_ready = 1'b0;
      mem_valid = 1'b0; mem_data = '0;
      #1;
      chk("reset_busy", 512'(busy), 512'(0));
      chk("reset_req", 512'(mem_req), 512'(0));
      chk("reset_update", 512'(cache_update), 512'(0));
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Basic miss, ready after 2 cycles, back-to-back beats
      s0 = strobes;
      do_miss(64'h1234, 64'h55, 20'h0ABCD, 16'h1357);
      chk("t1_req_high", 512'(mem_req), 512'(1));
      chk("t1_req_address", 512'(mem_req_address), 512'(64'h1200));
      tick(); tick();
      do_ready();
      chk("t1_req_dropped", 512'(mem_req), 512'(0));
      do_beat(ba); do_beat(bb); do_beat(bc); do_beat(bd);
      chk("t1_update_high", 512'(cache_update), 512'(1));
      chk("t1_line", upd_line, {ba, bb, bc, bd});
      chk("t1_pid", 512'(upd_pid), 512'(20'h0ABCD));
      chk("t1_address", 512'(upd_address), 512'(64'h1200));
      tick();
      chk("t1_update_low", 512'(cache_update), 512'(0));
      chk("t1_busy_low", 512'(busy), 512'(0));
      chk("t1_strobes", 512'(strobes - s0), 512'(1));

      // Interleaved beats, stray valid in REQ, ignored mid-fill miss, flush in WRITE
      s0 = strobes;
      mem_valid = 1'b1; mem_data = bh; tick(); mem_valid = 1'b0;
      do_miss(64'hFFFF_0000_0000_10BF, 64'h77, 20'h12345, 16'hBEEF);
      mem_valid = 1'b1; mem_data = bg; tick(); mem_valid = 1'b0;
      do_ready();
      do_beat(bd);
      do_miss(64'h9999_0000, 64'h1, 20'h1, 16'h1);
      for (int i = 0; i < 3; i++) begin
         repeat (gaps[i]) tick();
         do_beat((i == 0) ? bc : (i == 1) ? bb : ba);
      end
      chk("t2_update_high", 512'(cache_update), 512'(1));
      chk("t2_line", upd_line, {bd, bc, bb, ba});
      chk("t2_address", 512'(upd_address), 512'(64'hFFFF_0000_0000_1080));
      flush = 1'b1;
      tick();
      chk("t2_busy_low", 512'(busy), 512'(0));
      chk("t2_strobes", 512'(strobes - s0), 512'(1));

      // Flush together with a miss in IDLE: the miss is captured; then flush in REQ
      cache_miss = 1'b1; missed_address = 64'h2040; missed_major = 64'h3; missed_pid = 20'h3; missed_tid = 16'h3;
      tick();
      cache_miss = 1'b0; flush = 1'b0;
      chk("t3_req_after_flush_miss", 512'(mem_req), 512'(1));
      s0 = strobes;
      tick();
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t3_req_low", 512'(mem_req), 512'(0));
      chk("t3_busy_low", 512'(busy), 512'(0));
      tick(); tick();
      chk("t3_no_strobe", 512'(strobes - s0), 512'(0));

      // Flush after beat 1, remaining beats drained; then flush with ready in REQ
      s0 = strobes;
      do_miss(64'h3000, 64'h10, 20'h10, 16'h10);
      do_ready();
      do_beat(be); do_beat(bf);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t4_busy_drain", 512'(busy), 512'(1));
      do_beat(bg); tick(); do_beat(bh);
      chk("t4_busy_low", 512'(busy), 512'(0));
      do_miss(64'h3100, 64'h11, 20'h11, 16'h11);
      flush = 1'b1; mem_ready = 1'b1; tick(); flush = 1'b0; mem_ready = 1'b0;
      do_beat(ba); do_beat(bb); do_beat(bc); do_beat(bd);
      tick();
      chk("t4_no_strobe", 512'(strobes - s0), 512'(0));
      do_miss(64'h4321, 64'h12, 20'h12, 16'h12);
      do_ready();
      do_beat(bh); do_beat(bg); do_beat(bf); do_beat(be);
      chk("t4_new_line", upd_line, {bh, bg, bf, be});
      tick();

      // Reset after beat 2 of a fill, then a fresh miss
      do_miss(64'h5000, 64'h20, 20'h20, 16'h20);
      do_ready();
      do_beat(ba); do_beat(bb); do_beat(bc);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy_zero", 512'(busy), 512'(0));
      chk("t5_req_zero", 512'(mem_req), 512'(0));
      chk("t5_update_zero", 512'(cache_update), 512'(0));
      chk("t5_line_zero", upd_line, 512'(0));
      chk("t5_address_zero", 512'(mem_req_address), 512'(0));
      tick(); tick();
      rst_n = 1'b1;
      s0 = strobes;
      do_beat(bd);
      tick();
      chk("t5_idle_after_reset", 512'(busy), 512'(0));
      chk("t5_no_strobe", 512'(strobes - s0), 512'(0));
      do_miss(64'h6007, 64'h21, 20'h21, 16'h21);
      do_ready();
      do_beat(be); tick(); do_beat(bf); do_beat(bg); do_beat(bh);
      chk("t5_fresh_line", upd_line, {be, bf, bg, bh});
      chk("t5_fresh_address", 512'(upd_address), 512'(64'h6000));
      tick(); tick();
      chk("t5_strobes", 512'(strobes - s0), 512'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
